rv32i_writeback: RTL and testbench
==================================

RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning register address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_valid, input, 1, the MEM stage presents an instruction this cycle.
REQ-006 The block SHALL have port i_flush, input, 1, discard the MEM-stage instruction this cycle.
REQ-007 The block SHALL have ports i_reg_write (input, 1, writes rd) and i_rd_addr (input, ADDR_WIDTH, destination register).
REQ-008 The block SHALL have port i_wb_sel, input, 2: 00 = ALU, 01 = LOAD, 10 = PC+4, 11 = reserved, treated as ALU.
REQ-009 The block SHALL have ports i_alu_result, i_pc_plus4 and i_load_word, each input, WIDTH; i_load_word is the raw aligned memory word.
REQ-010 The block SHALL have ports i_load_funct3 (input, 3) and i_addr_lsb (input, 2), the load type and byte offset.
REQ-011 The block SHALL have MDU result ports i_mdu_valid (input, 1), o_mdu_ready (output, 1), i_mdu_rd_addr (input, ADDR_WIDTH) and i_mdu_data (input, WIDTH).
REQ-012 The block SHALL have register-file write ports o_we (output, 1), o_rd_addr (output, ADDR_WIDTH) and o_rd_data (output, WIDTH).
REQ-013 The block SHALL have hazard outputs o_mdu_pending (output, 1) and o_mdu_pending_rd (output, ADDR_WIDTH).
REQ-014 The block SHALL have forwarding outputs o_fwd_valid (output, 1), o_fwd_rd_addr (output, ADDR_WIDTH) and o_fwd_data (output, WIDTH), equal to the write port of the current cycle.

Function
REQ-015 The MEM/WB register SHALL capture all i_* pipeline fields each cycle, with valid = i_valid && !i_flush.
REQ-016 The pipeline write request SHALL be wb_valid && reg_write && rd != 0; rd = 0 never asserts o_we.
REQ-017 The result mux SHALL select ALU, aligned load or PC+4 from the registered wb_sel, combinationally in the WB cycle.
REQ-018 Load alignment SHALL work as follows:
- funct3 000/100 (LB/LBU): byte[addr_lsb], sign- or zero-extended.
- funct3 001/101 (LH/LHU): half[addr_lsb[1]], sign- or zero-extended.
- funct3 010 and all other values: the full word.
REQ-019 MDU handshake: a result transfers when i_mdu_valid && o_mdu_ready into a 1-entry hold register; o_mdu_ready = !hold_valid || hold_drain.
REQ-020 Arbitration: a pipeline write SHALL win the write port; the hold drains only in a cycle with no pipeline write request.
REQ-021 An MDU result SHALL reach o_we no earlier than the cycle after acceptance (minimum latency 1), even when the port is idle.
REQ-022 Simultaneous drain and accept SHALL leave hold_valid = 1 with the new entry.
REQ-023 An MDU result with rd = 0 SHALL be accepted and dropped, never asserting o_we.
REQ-024 o_mdu_pending SHALL equal hold_valid, and o_mdu_pending_rd SHALL equal the held rd; the hazard unit prevents younger writers to that rd.
REQ-025 i_flush SHALL NOT affect the hold register, which holds an older, committed result.

Reset
REQ-026 On rst_n low, wb_valid, hold_valid, o_we and o_fwd_valid SHALL be 0, and all data/address registers SHALL be 0.
REQ-027 Out of reset, o_mdu_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard any held MDU result and SHALL NOT emit a write.

Configuration
REQ-029 With RV32_WB_INSTRET_EN defined, the block SHALL add output o_instret (64 bits, reset 0), incremented by 1 per cycle with wb_valid high, wrapping at 2^64.
REQ-030 Without RV32_WB_INSTRET_EN, the o_instret port and its counter SHALL be absent.

Structure
REQ-031 The wb_sel encoding and load funct3 constants SHALL live in the shared package rv32i_pkg.
REQ-032 Load alignment SHALL be a sub-module rv32i_load_align, purely combinational.

Verification
REQ-033 LB, word 0x8070_60F0, lsb=0 -> o_rd_data 0xFFFF_FFF0; LBU lsb=3 -> 0x0000_0080; LHU lsb=2 -> 0x0000_8070.
REQ-034 i_valid=1, i_flush=1, ALU write to x5 -> no o_we the next cycle.
REQ-035 MDU x7=0x1234 accepted while the pipeline writes x3 for 2 consecutive cycles -> x3 is written twice, x7 follows in the 3rd cycle, and o_mdu_ready is 0 while the result is held.
REQ-036 Pipeline write with rd=0 and MDU result with rd=0 -> o_we stays 0, and the MDU result is consumed within 1 cycle.
REQ-037 rst_n pulsed low while hold_valid=1 -> no write, and o_mdu_ready=1 after release.
REQ-038 With RV32_WB_INSTRET_EN: 10 valid instructions and 3 bubbles -> o_instret=10; a counter preset to 2^64-1 plus one retire -> 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I write-back definitions: result-select encoding and load funct3 codes.
package rv32i_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load aligner: picks the addressed byte/half of an aligned word and extends it.
// Byte/half lanes are taken from the low 32 bits, so WIDTH must be at least 32.
module rv32i_load_align
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr_lsb,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by sign/zero extension by load type.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_word;
    case (i_addr_lsb)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    if (i_addr_lsb[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
    case (i_funct3)
      F3_LB:   o_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(WIDTH-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(WIDTH-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I write-back stage: MEM/WB register, result mux, and MDU result hold with write-port arbitration.
// Optional retired-instruction counter o_instret when RV32_WB_INSTRET_EN is defined.
module rv32i_writeback
  import rv32i_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [1:0]            i_wb_sel,
  input  logic [WIDTH-1:0]      i_alu_result,
  input  logic [WIDTH-1:0]      i_pc_plus4,
  input  logic [WIDTH-1:0]      i_load_word,
  input  logic [2:0]            i_load_funct3,
  input  logic [1:0]            i_addr_lsb,
  input  logic                  i_mdu_valid,
  output logic                  o_mdu_ready,
  input  logic [ADDR_WIDTH-1:0] i_mdu_rd_addr,
  input  logic [WIDTH-1:0]      i_mdu_data,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_mdu_pending,
  output logic [ADDR_WIDTH-1:0] o_mdu_pending_rd,
  output logic                  o_fwd_valid,
  output logic [ADDR_WIDTH-1:0] o_fwd_rd_addr,
  output logic [WIDTH-1:0]      o_fwd_data
`ifdef RV32_WB_INSTRET_EN
  ,
  output logic [63:0]           o_instret
`endif
);

  logic                  r_wb_valid;
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [1:0]            r_wb_sel;
  logic [WIDTH-1:0]      r_alu_result;
  logic [WIDTH-1:0]      r_pc_plus4;
  logic [WIDTH-1:0]      r_load_word;
  logic [2:0]            r_load_funct3;
  logic [1:0]            r_addr_lsb;

  logic                  r_hold_valid;
  logic [ADDR_WIDTH-1:0] r_hold_rd;
  logic [WIDTH-1:0]      r_hold_data;

  logic                  w_pipe_req;
  logic                  w_hold_drain;
  logic                  w_mdu_accept;
  logic [WIDTH-1:0]      w_load_data;
  logic [WIDTH-1:0]      w_pipe_data;

  assign w_pipe_req   = r_wb_valid && r_reg_write && (r_rd_addr != {ADDR_WIDTH{1'b0}});
  assign w_hold_drain = r_hold_valid && !w_pipe_req;
  assign o_mdu_ready  = !r_hold_valid || w_hold_drain;
  assign w_mdu_accept = i_mdu_valid && o_mdu_ready;

  assign o_mdu_pending    = r_hold_valid;
  assign o_mdu_pending_rd = r_hold_rd;

  // MEM/WB pipeline register; a flushed instruction is captured as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid    <= 1'b0;
      r_reg_write   <= 1'b0;
      r_rd_addr     <= {ADDR_WIDTH{1'b0}};
      r_wb_sel      <= 2'b00;
      r_alu_result  <= {WIDTH{1'b0}};
      r_pc_plus4    <= {WIDTH{1'b0}};
      r_load_word   <= {WIDTH{1'b0}};
      r_load_funct3 <= 3'b000;
      r_addr_lsb    <= 2'b00;
    end else begin
      r_wb_valid    <= i_valid && !i_flush;
      r_reg_write   <= i_reg_write;
      r_rd_addr     <= i_rd_addr;
      r_wb_sel      <= i_wb_sel;
      r_alu_result  <= i_alu_result;
      r_pc_plus4    <= i_pc_plus4;
      r_load_word   <= i_load_word;
      r_load_funct3 <= i_load_funct3;
      r_addr_lsb    <= i_addr_lsb;
    end
  end

  // MDU hold: x0 results are taken off the MDU but never held, so a held rd is always non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_rd    <= {ADDR_WIDTH{1'b0}};
      r_hold_data  <= {WIDTH{1'b0}};
    end else if (w_mdu_accept) begin
      r_hold_valid <= (i_mdu_rd_addr != {ADDR_WIDTH{1'b0}});
      r_hold_rd    <= i_mdu_rd_addr;
      r_hold_data  <= i_mdu_data;
    end else if (w_hold_drain) begin
      r_hold_valid <= 1'b0;
    end else begin
      r_hold_valid <= r_hold_valid;
    end
  end

  rv32i_load_align #(
    .WIDTH(WIDTH)
  ) u_load_align (
    .i_word    (r_load_word),
    .i_funct3  (r_load_funct3),
    .i_addr_lsb(r_addr_lsb),
    .o_data    (w_load_data)
  );

  // Result select; the reserved encoding falls back to the ALU result.
  always_comb begin
    w_pipe_data = r_alu_result;
    case (wb_sel_e'(r_wb_sel))
      WB_LOAD: w_pipe_data = w_load_data;
      WB_PC4:  w_pipe_data = r_pc_plus4;
      default: w_pipe_data = r_alu_result;
    endcase
  end

  // Write-port arbitration: the in-order pipeline always wins over a held MDU result.
  always_comb begin
    o_we      = 1'b0;
    o_rd_addr = {ADDR_WIDTH{1'b0}};
    o_rd_data = {WIDTH{1'b0}};
    if (w_pipe_req) begin
      o_we      = 1'b1;
      o_rd_addr = r_rd_addr;
      o_rd_data = w_pipe_data;
    end else if (w_hold_drain) begin
      o_we      = 1'b1;
      o_rd_addr = r_hold_rd;
      o_rd_data = r_hold_data;
    end else begin
      o_we      = 1'b0;
    end
  end

  assign o_fwd_valid   = o_we;
  assign o_fwd_rd_addr = o_rd_addr;
  assign o_fwd_data    = o_rd_data;

`ifdef RV32_WB_INSTRET_EN
  logic [63:0] r_instret;

  // Retired-instruction count, wrapping naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= 64'd0;
    end else if (r_wb_valid) begin
      r_instret <= r_instret + 64'd1;
    end else begin
      r_instret <= r_instret;
    end
  end

  assign o_instret = r_instret;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: directed vector table, corner sequences, random vs. reference model.
module tb_rv32i_writeback;

  logic        clk;
  logic        rst_n;
  logic        i_valid, i_flush, i_reg_write;
  logic [4:0]  i_rd_addr;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_result, i_pc_plus4, i_load_word;
  logic [2:0]  i_load_funct3;
  logic [1:0]  i_addr_lsb;
  logic        i_mdu_valid;
  logic        o_mdu_ready;
  logic [4:0]  i_mdu_rd_addr;
  logic [31:0] i_mdu_data;
  logic        o_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_mdu_pending;
  logic [4:0]  o_mdu_pending_rd;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd_addr;
  logic [31:0] o_fwd_data;
`ifdef RV32_WB_INSTRET_EN
  logic [63:0] o_instret;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rv32i_writeback dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_valid         (i_valid),
    .i_flush         (i_flush),
    .i_reg_write     (i_reg_write),
    .i_rd_addr       (i_rd_addr),
    .i_wb_sel        (i_wb_sel),
    .i_alu_result    (i_alu_result),
    .i_pc_plus4      (i_pc_plus4),
    .i_load_word     (i_load_word),
    .i_load_funct3   (i_load_funct3),
    .i_addr_lsb      (i_addr_lsb),
    .i_mdu_valid     (i_mdu_valid),
    .o_mdu_ready     (o_mdu_ready),
    .i_mdu_rd_addr   (i_mdu_rd_addr),
    .i_mdu_data      (i_mdu_data),
    .o_we            (o_we),
    .o_rd_addr       (o_rd_addr),
    .o_rd_data       (o_rd_data),
    .o_mdu_pending   (o_mdu_pending),
    .o_mdu_pending_rd(o_mdu_pending_rd),
    .o_fwd_valid     (o_fwd_valid),
    .o_fwd_rd_addr   (o_fwd_rd_addr),
    .o_fwd_data      (o_fwd_data)
`ifdef RV32_WB_INSTRET_EN
    ,
    .o_instret       (o_instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] word;
    logic [4:0]  rd;
    logic        rw;
    logic        flush;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } mdu_t;

  vec_t vq[$];
  mdu_t hq[$];

  localparam logic [31:0] ALU_K = 32'hA1A1_0001;
  localparam logic [31:0] PC4_K = 32'h0000_1004;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] sel, input logic [2:0] f3,
                              input logic [1:0] lsb, input logic [31:0] word, input logic [4:0] rd,
                              input logic rw, input logic fl, input logic we, input logic [31:0] d);
    vec_t v;
    v.name = nm; v.sel = sel; v.f3 = f3; v.lsb = lsb; v.word = word; v.rd = rd;
    v.rw = rw; v.flush = fl; v.exp_we = we; v.exp_data = d;
    return v;
  endfunction

  // Reference load extraction from the architectural rules (shift and mask).
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * lsb)) & 32'h0000_00FF;
    h = (word >> (16 * lsb[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  task automatic drive_pipe(input logic v, input logic fl, input logic rw, input logic [4:0] rd,
                            input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lsb,
                            input logic [31:0] word, input logic [31:0] alu, input logic [31:0] pc4);
    i_valid = v; i_flush = fl; i_reg_write = rw; i_rd_addr = rd; i_wb_sel = sel;
    i_load_funct3 = f3; i_addr_lsb = lsb; i_load_word = word; i_alu_result = alu; i_pc_plus4 = pc4;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    i_mdu_valid = v; i_mdu_rd_addr = rd; i_mdu_data = d;
  endtask

  task automatic idle();
    drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [1:0]  m_lsb;
    logic [31:0] m_word, m_alu, m_pc4;
    logic        exp_pipe, exp_we, exp_ready;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        nv, nfl;
    mdu_t        e;

    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_we", {63'd0, o_we}, 64'd0);
    chk("reset_fwd_valid", {63'd0, o_fwd_valid}, 64'd0);
    chk("reset_pending", {63'd0, o_mdu_pending}, 64'd0);
    chk("reset_pending_rd", {59'd0, o_mdu_pending_rd}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, o_mdu_ready}, 64'd1);

    // Directed vector table: one pipeline instruction per cycle, result seen the cycle after.
    vq.push_back(mk("lb_lsb0",   2'b01, 3'b000, 2'd0, 32'h8070_60F0, 5'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0));
    vq.push_back(mk("lbu_lsb3",  2'b01, 3'b100, 2'd3, 32'h8070_60F0, 5'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0080));
    vq.push_back(mk("lhu_lsb2",  2'b01, 3'b101, 2'd2, 32'h8070_60F0, 5'd3, 1'b1, 1'b0, 1'b1, 32'h0000_8070));
    vq.push_back(mk("lh_lsb2",   2'b01, 3'b001, 2'd2, 32'h8070_60F0, 5'd4, 1'b1, 1'b0, 1'b1, 32'hFFFF_8070));
    vq.push_back(mk("lh_lsb0",   2'b01, 3'b001, 2'd0, 32'h8070_60F0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0000_60F0));
    vq.push_back(mk("lb_lsb1",   2'b01, 3'b000, 2'd1, 32'h8070_60F0, 5'd6, 1'b1, 1'b0, 1'b1, 32'h0000_0060));
    vq.push_back(mk("lw",        2'b01, 3'b010, 2'd0, 32'h8070_60F0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h8070_60F0));
    vq.push_back(mk("f3_011",    2'b01, 3'b011, 2'd1, 32'h1357_9BDF, 5'd9, 1'b1, 1'b0, 1'b1, 32'h1357_9BDF));
    vq.push_back(mk("sel_pc4",   2'b10, 3'b000, 2'd0, 32'h8070_60F0, 5'd10, 1'b1, 1'b0, 1'b1, PC4_K));
    vq.push_back(mk("sel_alu",   2'b00, 3'b000, 2'd0, 32'h8070_60F0, 5'd11, 1'b1, 1'b0, 1'b1, ALU_K));
    vq.push_back(mk("sel_rsvd",  2'b11, 3'b000, 2'd0, 32'h8070_60F0, 5'd12, 1'b1, 1'b0, 1'b1, ALU_K));
    vq.push_back(mk("flush_x5",  2'b00, 3'b000, 2'd0, 32'h0,         5'd5, 1'b1, 1'b1, 1'b0, 32'h0));
    vq.push_back(mk("rd_zero",   2'b00, 3'b000, 2'd0, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0, 32'h0));
    vq.push_back(mk("no_regwr",  2'b00, 3'b000, 2'd0, 32'h0,         5'd13, 1'b0, 1'b0, 1'b0, 32'h0));
    foreach (vq[k]) begin
      drive_pipe(1'b1, vq[k].flush, vq[k].rw, vq[k].rd, vq[k].sel, vq[k].f3, vq[k].lsb,
                 vq[k].word, ALU_K, PC4_K);
      @(negedge clk);
      chk({vq[k].name, "_we"}, {63'd0, o_we}, {63'd0, vq[k].exp_we});
      if (vq[k].exp_we) begin
        chk({vq[k].name, "_rd"}, {59'd0, o_rd_addr}, {59'd0, vq[k].rd});
        chk({vq[k].name, "_data"}, {32'd0, o_rd_data}, {32'd0, vq[k].exp_data});
        chk({vq[k].name, "_fwd"}, {32'd0, o_fwd_data}, {32'd0, vq[k].exp_data});
      end
    end
    idle();
    @(negedge clk);

    // MDU result held behind two pipeline writes to x3, then drained.
    drive_pipe(1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'd0, 32'h0000_0033, 32'd0);
    drive_mdu(1'b1, 5'd7, 32'h0000_1234);
    #1 chk("seq35_ready_empty", {63'd0, o_mdu_ready}, 64'd1);
    @(negedge clk);
    drive_mdu(1'b0, 5'd0, 32'd0);
    drive_pipe(1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'd0, 32'h0000_0034, 32'd0);
    chk("seq35_w1_rd", {58'd0, o_we, o_rd_addr}, {58'd0, 1'b1, 5'd3});
    chk("seq35_w1_data", {32'd0, o_rd_data}, 64'h33);
    chk("seq35_pending", {58'd0, o_mdu_pending, o_mdu_pending_rd}, {58'd0, 1'b1, 5'd7});
    chk("seq35_ready_w1", {63'd0, o_mdu_ready}, 64'd0);
    @(negedge clk);
    idle();
    chk("seq35_w2_rd", {58'd0, o_we, o_rd_addr}, {58'd0, 1'b1, 5'd3});
    chk("seq35_w2_data", {32'd0, o_rd_data}, 64'h34);
    chk("seq35_ready_w2", {63'd0, o_mdu_ready}, 64'd0);
    @(negedge clk);
    chk("seq35_w3_rd", {58'd0, o_we, o_rd_addr}, {58'd0, 1'b1, 5'd7});
    chk("seq35_w3_data", {32'd0, o_rd_data}, 64'h1234);
    @(negedge clk);
    chk("seq35_after_we", {63'd0, o_we}, 64'd0);
    chk("seq35_after_pending", {63'd0, o_mdu_pending}, 64'd0);

    // x0 from both the pipeline and the MDU: nothing written, MDU result gone in one cycle.
    drive_pipe(1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 3'b000, 2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0);
    drive_mdu(1'b1, 5'd0, 32'hCAFE_F00D);
    @(negedge clk);
    idle();
    chk("seq36_we0", {63'd0, o_we}, 64'd0);
    @(negedge clk);
    chk("seq36_we1", {63'd0, o_we}, 64'd0);
    chk("seq36_pending", {63'd0, o_mdu_pending}, 64'd0);
    chk("seq36_ready", {63'd0, o_mdu_ready}, 64'd1);

    // Reset while a result is held must drop it silently.
    drive_pipe(1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'd0, 32'h55, 32'd0);
    drive_mdu(1'b1, 5'd9, 32'h0000_9999);
    @(negedge clk);
    idle();
    chk("seq37_held", {63'd0, o_mdu_pending}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("seq37_rst_we", {63'd0, o_we}, 64'd0);
    chk("seq37_rst_pending", {63'd0, o_mdu_pending}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("seq37_ready", {63'd0, o_mdu_ready}, 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("seq37_no_write", {63'd0, o_we}, 64'd0);
    end

    // Randomized traffic against a queue-based reference of the write-port rules.
    do_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_sel = 2'b00; m_f3 = 3'b000; m_lsb = 2'b00;
    m_word = 32'd0; m_alu = 32'd0; m_pc4 = 32'd0;
    hq.delete();
    for (int c = 0; c < 400; c++) begin
      exp_pipe = m_valid && m_rw && (m_rd != 5'd0);
      exp_we   = exp_pipe || (hq.size() != 0);
      exp_rd   = 5'd0;
      exp_data = 32'd0;
      if (exp_pipe) begin
        exp_rd   = m_rd;
        exp_data = (m_sel == 2'b01) ? ref_load(m_f3, m_lsb, m_word) :
                   (m_sel == 2'b10) ? m_pc4 : m_alu;
      end else if (hq.size() != 0) begin
        exp_rd   = hq[0].rd;
        exp_data = hq[0].data;
      end
      exp_ready = (hq.size() == 0) || !exp_pipe;
      chk("rnd_we", {63'd0, o_we}, {63'd0, exp_we});
      chk("rnd_fwd_valid", {63'd0, o_fwd_valid}, {63'd0, exp_we});
      if (exp_we) begin
        chk("rnd_rd", {59'd0, o_rd_addr}, {59'd0, exp_rd});
        chk("rnd_data", {32'd0, o_rd_data}, {32'd0, exp_data});
        chk("rnd_fwd_rd", {59'd0, o_fwd_rd_addr}, {59'd0, exp_rd});
        chk("rnd_fwd_data", {32'd0, o_fwd_data}, {32'd0, exp_data});
      end
      chk("rnd_ready", {63'd0, o_mdu_ready}, {63'd0, exp_ready});
      chk("rnd_pending", {63'd0, o_mdu_pending}, {63'd0, (hq.size() != 0)});
      if (hq.size() != 0) chk("rnd_pending_rd", {59'd0, o_mdu_pending_rd}, {59'd0, hq[0].rd});
      if (!exp_pipe && hq.size() != 0) void'(hq.pop_front());

      nv  = ($urandom_range(0, 3) != 0);
      nfl = ($urandom_range(0, 4) == 0);
      drive_pipe(nv, nfl, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                 2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
      drive_mdu(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
      if (i_mdu_valid && exp_ready && (i_mdu_rd_addr != 5'd0)) begin
        e.rd = i_mdu_rd_addr; e.data = i_mdu_data;
        hq.push_back(e);
      end
      m_valid = nv && !nfl; m_rw = i_reg_write; m_rd = i_rd_addr; m_sel = i_wb_sel;
      m_f3 = i_load_funct3; m_lsb = i_addr_lsb; m_word = i_load_word; m_alu = i_alu_result;
      m_pc4 = i_pc_plus4;
      @(negedge clk);
    end
    idle();

`ifdef RV32_WB_INSTRET_EN
    do_reset();
    chk("instret_reset", o_instret, 64'd0);
    for (int k = 0; k < 13; k++) begin
      if (k == 2 || k == 6 || k == 11) idle();
      else drive_pipe(1'b1, 1'b0, 1'($urandom), 5'($urandom), 2'b00, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    chk("instret_10", o_instret, 64'd10);
    drive_pipe(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    idle();
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.r_instret;
    @(negedge clk);
    chk("instret_wrap", o_instret, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
